// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register indices, exception codes, field positions.
// Optional BadVAddr support is enabled by defining CP0_BADVADDR_EN.
package cp0_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_SR       = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int SR_IE    = 0;
  localparam int SR_EXL   = 1;
  localparam int IM_LO    = 10;
  localparam int IM_HI    = 15;
  localparam int IP_LO    = 10;
  localparam int IP_HI    = 15;
  localparam int EXC_LO   = 2;
  localparam int EXC_HI   = 6;
  localparam int CAUSE_BD = 31;

  typedef enum logic {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } cp0_state_e;

  // Return address for a faulting instruction; a delay slot returns to its branch.
  function automatic logic [31:0] epc_of(
    input logic [31:0] pc,
    input logic        bd
  );
    logic [31:0] e;
    e = bd ? pc - 32'd4 : pc;
    return {e[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_arb.sv
// CP0 request arbitration: interrupt/exception/eret decision and redirect PC.
// Purely combinational; reset forces all outputs low.
module cp0_arb
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
  input  logic        rst,
  input  logic [5:0]  hwint,
  input  logic [5:0]  im,
  input  logic        ie,
  input  logic        exl,
  input  logic [4:0]  exc_code,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic        activate,
  output logic        cool,
  output logic        take_int,
  output logic [31:0] npc
);

  logic int_req;
  logic exc_req;

  always_comb begin
    int_req  = (|(hwint & im)) & ie & ~exl;
    exc_req  = (exc_code != EXC_INT) & ~exl;
    take_int = ~rst & int_req;
    activate = ~rst & (int_req | exc_req);
    cool     = ~rst & eret & exl & ~activate;
    npc      = '0;
    unique case (1'b1)
      activate: npc = HANDLER_ADDR;
      cool:     npc = epc;
      default:  ;
    endcase
  end

endmodule

// File: rtl/cp0_unit.sv
// CP0 coprocessor: SR/Cause/EPC/PRId, precise exception and eret control.
// Define CP0_BADVADDR_EN to add the BadVAddr_M port and BadVAddr register.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID_VALUE   = 32'h2020_1217
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [4:0]  ExcCode_M,
  input  logic [31:0] PC_M,
  input  logic        BD_M,
  input  logic [5:0]  HWInt,
  input  logic        EretM,
  input  logic        CP0We,
  input  logic [4:0]  CP0Addr,
  input  logic [31:0] CP0WData,
`ifdef CP0_BADVADDR_EN
  input  logic [31:0] BadVAddr_M,
`endif
  output logic [31:0] CP0RData,
  output logic        ActivateCP0,
  output logic        CoolCP0,
  output logic [31:0] NPC_CP0
);

  cp0_state_e state_q, state_d;

  logic [5:0]  sr_im;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc_q;
  logic [31:0] bv_rd;

  logic        exl;
  logic        take_int;
  logic        we_ok;
  logic        sr_clr;
  logic [31:0] sr_rd;
  logic [31:0] cause_rd;

  assign exl = (state_q == HANDLER);

  cp0_arb #(
    .HANDLER_ADDR(HANDLER_ADDR)
  ) u_arb (
    .rst      (Rst),
    .hwint    (HWInt),
    .im       (sr_im),
    .ie       (sr_ie),
    .exl      (exl),
    .exc_code (ExcCode_M),
    .eret     (EretM),
    .epc      (epc_q),
    .activate (ActivateCP0),
    .cool     (CoolCP0),
    .take_int (take_int),
    .npc      (NPC_CP0)
  );

  // A taken exception squashes the mtc0 in the same cycle.
  assign we_ok  = CP0We & ~ActivateCP0;
  assign sr_clr = we_ok & (CP0Addr == REG_SR)
                & ~CP0WData[SR_EXL];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (ActivateCP0) state_d = HANDLER;
      HANDLER: if (CoolCP0 || sr_clr) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= RUN;
      sr_im     <= '0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc_q     <= '0;
    end else begin
      state_q  <= state_d;
      cause_ip <= HWInt;
      if (ActivateCP0) begin
        cause_bd  <= BD_M;
        cause_exc <= take_int ? EXC_INT : ExcCode_M;
        epc_q     <= epc_of(PC_M, BD_M);
      end else if (we_ok) begin
        if (CP0Addr == REG_SR) begin
          sr_im <= CP0WData[IM_HI:IM_LO];
          sr_ie <= CP0WData[SR_IE];
        end
        if (CP0Addr == REG_EPC)
          epc_q <= {CP0WData[31:2], 2'b00};
      end
    end
  end

`ifdef CP0_BADVADDR_EN
  logic [31:0] bv_q;
  logic        bv_cap;

  assign bv_cap = ActivateCP0 & ~take_int
                & ((ExcCode_M == EXC_ADEL)
                 | (ExcCode_M == EXC_ADES));

  always_ff @(posedge Clk) begin
    if (Rst)         bv_q <= '0;
    else if (bv_cap) bv_q <= BadVAddr_M;
  end

  assign bv_rd = bv_q;
`else
  assign bv_rd = '0;
`endif

  always_comb begin
    sr_rd                    = '0;
    sr_rd[IM_HI:IM_LO]       = sr_im;
    sr_rd[SR_EXL]            = exl;
    sr_rd[SR_IE]             = sr_ie;
    cause_rd                 = '0;
    cause_rd[CAUSE_BD]       = cause_bd;
    cause_rd[IP_HI:IP_LO]    = cause_ip;
    cause_rd[EXC_HI:EXC_LO]  = cause_exc;
  end

  always_comb begin
    CP0RData = '0;
    unique case (1'b1)
      (CP0Addr == REG_SR):       CP0RData = sr_rd;
      (CP0Addr == REG_CAUSE):    CP0RData = cause_rd;
      (CP0Addr == REG_EPC):      CP0RData = epc_q;
      (CP0Addr == REG_PRID):     CP0RData = PRID_VALUE;
      (CP0Addr == REG_BADVADDR): CP0RData = bv_rd;
      default:                   ;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: cycle model plus directed literal checks.
// Honours CP0_BADVADDR_EN when the design is built with it.
module tb_cp0_unit;

  logic        Clk;
  logic        Rst;
  logic [4:0]  ExcCode_M;
  logic [31:0] PC_M;
  logic        BD_M;
  logic [5:0]  HWInt;
  logic        EretM;
  logic        CP0We;
  logic [4:0]  CP0Addr;
  logic [31:0] CP0WData;
  logic [31:0] CP0RData;
  logic        ActivateCP0;
  logic        CoolCP0;
  logic [31:0] NPC_CP0;
  logic [31:0] BadVAddr_M;

  int checks   = 0;
  int failures = 0;

  cp0_unit dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .ExcCode_M   (ExcCode_M),
    .PC_M        (PC_M),
    .BD_M        (BD_M),
    .HWInt       (HWInt),
    .EretM       (EretM),
    .CP0We       (CP0We),
    .CP0Addr     (CP0Addr),
    .CP0WData    (CP0WData),
`ifdef CP0_BADVADDR_EN
    .BadVAddr_M  (BadVAddr_M),
`endif
    .CP0RData    (CP0RData),
    .ActivateCP0 (ActivateCP0),
    .CoolCP0     (CoolCP0),
    .NPC_CP0     (NPC_CP0)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Architectural model of the visible CP0 state
  logic [5:0]  m_im;
  logic        m_ie;
  logic        m_exl;
  logic        m_bd;
  logic [5:0]  m_ip;
  logic [4:0]  m_exc;
  logic [31:0] m_epc;
  logic [31:0] m_bv;

  initial begin
    m_im = 0; m_ie = 0; m_exl = 0; m_bd = 0;
    m_ip = 0; m_exc = 0; m_epc = 0; m_bv = 0;
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] a);
    case (a)
      5'd12: return (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
      5'd13: return (32'(m_bd) << 31) | (32'(m_ip) << 10) | (32'(m_exc) << 2);
      5'd14: return m_epc;
      5'd15: return 32'h2020_1217;
`ifdef CP0_BADVADDR_EN
      5'd8:  return m_bv;
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_int();
    return ((HWInt & m_im) != 0) && m_ie && !m_exl;
  endfunction

  function automatic logic m_take();
    return !Rst && (m_int() || (ExcCode_M != 0 && !m_exl));
  endfunction

  function automatic logic m_cool();
    return !Rst && EretM && m_exl && !m_take();
  endfunction

  always @(posedge Clk) begin
    if (Rst) begin
      m_im <= 0; m_ie <= 0; m_exl <= 0; m_bd <= 0;
      m_ip <= 0; m_exc <= 0; m_epc <= 0; m_bv <= 0;
    end else begin
      m_ip <= HWInt;
      if (m_take()) begin
        m_exl <= 1'b1;
        m_bd  <= BD_M;
        m_exc <= m_int() ? 5'd0 : ExcCode_M;
        m_epc <= (BD_M ? PC_M - 32'd4 : PC_M) & 32'hFFFF_FFFC;
        if (!m_int() && (ExcCode_M == 5'd4 || ExcCode_M == 5'd5))
          m_bv <= BadVAddr_M;
      end else begin
        if (m_cool()) m_exl <= 1'b0;
        if (CP0We && CP0Addr == 5'd12) begin
          m_im <= CP0WData[15:10];
          m_ie <= CP0WData[0];
          if (!CP0WData[1]) m_exl <= 1'b0;
        end
        if (CP0We && CP0Addr == 5'd14)
          m_epc <= CP0WData & 32'hFFFF_FFFC;
      end
    end
  end

  always @(negedge Clk) begin
    logic t, c;
    t = m_take();
    c = m_cool();
    chk("m_activate", 32'(ActivateCP0), 32'(t));
    chk("m_cool", 32'(CoolCP0), 32'(c));
    chk("m_npc", NPC_CP0, t ? 32'h4180 : (c ? m_epc : 32'h0));
    chk("m_rdata", CP0RData, mread(CP0Addr));
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic rd(input string name,
                    input logic [4:0] a,
                    input logic [31:0] exp);
    CP0Addr = a;
    #1;
    chk(name, CP0RData, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    CP0We = 1'b1; CP0Addr = a; CP0WData = d;
    tick();
    CP0We = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; ExcCode_M = 5'd12; PC_M = 32'h3000; BD_M = 1'b0;
    HWInt = 6'h3f; EretM = 1'b0; CP0We = 1'b1; CP0Addr = 5'd12;
    CP0WData = 32'hFFFF_FFFF; BadVAddr_M = 32'hDEAD_0001;
    #1;
    chk("rst_act", 32'(ActivateCP0), 32'h0);
    chk("rst_npc", NPC_CP0, 32'h0);
    tick(); tick();
    Rst = 1'b0; ExcCode_M = 0; CP0We = 1'b0; HWInt = 0;
    rd("rst_sr", 5'd12, 32'h0);
    rd("rst_cause", 5'd13, 32'h0);
    rd("rst_epc", 5'd14, 32'h0);

    wr(5'd12, 32'h0000_0401);
    rd("sr_wr", 5'd12, 32'h0000_0401);

    HWInt = 6'b000001; PC_M = 32'h3000;
    #1;
    chk("int_act", 32'(ActivateCP0), 32'h1);
    chk("int_npc", NPC_CP0, 32'h4180);
    tick();
    HWInt = 0;
    rd("int_cause", 5'd13, 32'h0000_0400);
    rd("int_sr", 5'd12, 32'h0000_0403);
    rd("int_epc", 5'd14, 32'h0000_3000);

    wr(5'd14, 32'h3010);
    rd("epc_wr", 5'd14, 32'h3010);

    EretM = 1'b1;
    #1;
    chk("eret_cool", 32'(CoolCP0), 32'h1);
    chk("eret_npc", NPC_CP0, 32'h3010);
    tick();
    EretM = 1'b0;
    rd("eret_sr", 5'd12, 32'h0000_0401);

    ExcCode_M = 5'd12; PC_M = 32'h3010; BD_M = 1'b1;
    CP0We = 1'b1; CP0Addr = 5'd12; CP0WData = 32'h0;
    #1;
    chk("ov_act", 32'(ActivateCP0), 32'h1);
    tick();
    ExcCode_M = 0; BD_M = 0; CP0We = 0;
    rd("ov_epc", 5'd14, 32'h0000_300C);
    rd("ov_cause", 5'd13, 32'h8000_0030);
    rd("ov_sr_nowr", 5'd12, 32'h0000_0403);

    ExcCode_M = 5'd4; HWInt = 6'b000001;
    #1;
    chk("nest_act", 32'(ActivateCP0), 32'h0);
    tick();
    ExcCode_M = 0; HWInt = 0;
    rd("nest_cause", 5'd13, 32'h8000_0430);
    rd("nest_epc", 5'd14, 32'h0000_300C);
    rd("nest_sr", 5'd12, 32'h0000_0403);

    EretM = 1'b1; CP0We = 1'b1; CP0Addr = 5'd14; CP0WData = 32'h5000;
    #1;
    chk("eretwr_cool", 32'(CoolCP0), 32'h1);
    chk("eretwr_npc", NPC_CP0, 32'h0000_300C);
    tick();
    EretM = 0; CP0We = 0;
    rd("eretwr_epc", 5'd14, 32'h5000);
    rd("eretwr_sr", 5'd12, 32'h0000_0401);

    wr(5'd12, 32'h0000_0400);
    HWInt = 6'b000001;
    #1;
    chk("ie0_act", 32'(ActivateCP0), 32'h0);
    tick();
    HWInt = 0;
    wr(5'd12, 32'h0000_0401);

    ExcCode_M = 5'd10; HWInt = 6'b000001; PC_M = 32'h3020;
    #1;
    chk("pri_act", 32'(ActivateCP0), 32'h1);
    tick();
    ExcCode_M = 0; HWInt = 0;
    rd("pri_cause", 5'd13, 32'h0000_0400);
    rd("pri_epc", 5'd14, 32'h0000_3020);

    wr(5'd13, 32'hFFFF_FFFF);
    rd("cause_ro", 5'd13, 32'h0);

    wr(5'd12, 32'h0000_0401);
    rd("exl_clr", 5'd12, 32'h0000_0401);

    rd("prid", 5'd15, 32'h2020_1217);
    rd("unmapped", 5'd3, 32'h0);
`ifndef CP0_BADVADDR_EN
    rd("badvaddr_off", 5'd8, 32'h0);
`endif

    wr(5'd14, 32'h1237);
    rd("epc_align", 5'd14, 32'h1234);

    ExcCode_M = 5'd12;
    tick();
    Rst = 1'b1; CP0We = 1'b1; CP0Addr = 5'd14; CP0WData = 32'hFFFF;
    #1;
    chk("rst2_act", 32'(ActivateCP0), 32'h0);
    chk("rst2_cool", 32'(CoolCP0), 32'h0);
    tick();
    Rst = 1'b0; CP0We = 1'b0; ExcCode_M = 0;
    rd("rst2_sr", 5'd12, 32'h0);
    rd("rst2_cause", 5'd13, 32'h0);
    rd("rst2_epc", 5'd14, 32'h0);

    ExcCode_M = 5'd12;
    #1;
    chk("rst2_run", 32'(ActivateCP0), 32'h1);
    tick();
    ExcCode_M = 0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
